alu_result_reader: RTL and testbench

Read-side port for the ALU result store. It accepts writes from the 3-stage ALU's result stage into a 32-entry × 32-bit result array and serves addressed read requests through a 2-stage valid/ready pipeline with backpressure. A per-entry written-flag bitmap makes responses deterministic after reset. Same-cycle write-to-read forwarding gives write-first semantics.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_result_store.sv | 56 +++++
 rtl/alu_result_reader.sv | 97 +++++++++
 tb/tb_alu_result_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU and its result store.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  // ALU opcode, shared with the ALU datapath.
  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_XOR = 2'd2,
    ALU_ADD = 2'd3
  } alu_op_e;

  // Payload held by the read-response stage.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              written;
    logic [DATA_W-1:0] data;
  } rd_rsp_t;

endpackage : alu_pkg

// File: rtl/alu_result_store.sv
// Result array, written-flag bitmap and write-first read mux.
module alu_result_store
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              rd_written_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  written_q;
  logic [DEPTH-1:0]  written_d;

  // Array storage; intentionally not reset, the bitmap masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next bitmap: mark every written entry.
  always_comb begin
    written_d = written_q;
    if (wr_valid) begin
      written_d[wr_addr] = 1'b1;
    end
  end

  // Bitmap register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else begin
      written_q <= written_d;
    end
  end

  // Read mux: same-cycle write wins, unwritten entries read as zero.
  always_comb begin
    rd_data_c    = '0;
    rd_written_c = 1'b0;
    if (wr_valid && (wr_addr == rd_addr)) begin
      rd_data_c    = wr_data;
      rd_written_c = 1'b1;
    end else if (written_q[rd_addr]) begin
      rd_data_c    = mem_q[rd_addr];
      rd_written_c = 1'b1;
    end
  end

endmodule : alu_result_store

// File: rtl/alu_result_reader.sv
// Read port for the ALU result store: 2-stage valid/ready pipeline.
module alu_result_reader
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic [ADDR_W-1:0] rd_rsp_addr,
  output logic              rd_rsp_written,
  output logic [1:0]        pending
);

  logic              r1_valid_q, r1_valid_d;
  logic [ADDR_W-1:0] r1_addr_q, r1_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  rd_rsp_t           rsp_q, rsp_d;

  logic              out_adv;
  logic              r1_adv;
  logic              accept;
  logic [DATA_W-1:0] st_data_c;
  logic              st_written_c;

  alu_result_store u_store (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (r1_addr_q),
    .rd_data_c    (st_data_c),
    .rd_written_c (st_written_c)
  );

  // Handshake and next-state for R1 and the output stage.
  always_comb begin
    out_adv      = !rsp_valid_q || rd_rsp_ready;
    r1_adv       = r1_valid_q && out_adv;
    rd_req_ready = !r1_valid_q || out_adv;
    accept       = rd_req_valid && rd_req_ready;

    r1_valid_d  = r1_valid_q;
    r1_addr_d   = r1_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    if (accept) begin
      r1_valid_d = 1'b1;
      r1_addr_d  = rd_req_addr;
    end else if (r1_adv) begin
      r1_valid_d = 1'b0;
    end

    // Data is sampled at transfer time so a stalled R1 sees late writes.
    if (out_adv) begin
      rsp_valid_d = r1_valid_q;
      if (r1_valid_q) begin
        rsp_d.addr    = r1_addr_q;
        rsp_d.written = st_written_c;
        rsp_d.data    = st_data_c;
      end
    end
  end

  // Pipeline registers; in-flight requests are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid_q  <= 1'b0;
      r1_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      r1_valid_q  <= r1_valid_d;
      r1_addr_q   <= r1_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  // Output wiring from registered state.
  always_comb begin
    rd_rsp_valid   = rsp_valid_q;
    rd_rsp_data    = rsp_q.data;
    rd_rsp_addr    = rsp_q.addr;
    rd_rsp_written = rsp_q.written;
    pending        = 2'(r1_valid_q) + 2'(rsp_valid_q);
  end

endmodule : alu_result_reader

// File: tb/tb_alu_result_reader.sv
// Scoreboard bench for alu_result_reader.
module tb_alu_result_reader;
  import alu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [DATA_W-1:0] rd_rsp_data;
  logic [ADDR_W-1:0] rd_rsp_addr;
  logic              rd_rsp_written;
  logic [1:0]        pending;

  int n_pass;
  int n_total;
  rd_rsp_t exp_q[$];

  alu_result_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_addr    (rd_req_addr),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_ready   (rd_rsp_ready),
    .rd_rsp_data    (rd_rsp_data),
    .rd_rsp_addr    (rd_rsp_addr),
    .rd_rsp_written (rd_rsp_written),
    .pending        (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic w);
    rd_rsp_t e;
    e.addr = a;
    e.data = d;
    e.written = w;
    exp_q.push_back(e);
  endtask

  // Monitor: a response transfers on the next edge when valid && ready mid-cycle.
  always @(negedge clk) begin
    if (rst_n && rd_rsp_valid && rd_rsp_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got addr=%0d data=%h written=%0b expected none",
                 rd_rsp_addr, rd_rsp_data, rd_rsp_written);
      end else begin
        rd_rsp_t e;
        e = exp_q.pop_front();
        if (rd_rsp_addr === e.addr && rd_rsp_data === e.data && rd_rsp_written === e.written)
          n_pass++;
        else
          $display("FAIL rsp: got addr=%0d data=%h written=%0b expected addr=%0d data=%h written=%0b",
                   rd_rsp_addr, rd_rsp_data, rd_rsp_written, e.addr, e.data, e.written);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_req_valid = 1'b0;
    rd_req_addr = '0;
    rd_rsp_ready = 1'b1;
    n_pass = 0;
    n_total = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("reset_rsp_data", rd_rsp_data, 32'd0);
    check("reset_rsp_addr", 32'(rd_rsp_addr), 32'd0);
    check("reset_rsp_written", 32'(rd_rsp_written), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_req_ready", 32'(rd_req_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Unwritten entry reads as zero; response two edges after request.
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd7;
    push(5'd7, 32'h0, 1'b0);
    tick();
    rd_req_valid = 1'b0;
    check("lat_r1_pending", 32'(pending), 32'd1);
    check("lat_not_yet", 32'(rd_rsp_valid), 32'd0);
    tick();
    check("lat_rsp_valid", 32'(rd_rsp_valid), 32'd1);
    tick();

    // Write then read.
    wr_valid = 1'b1;
    wr_addr = 5'd16;
    wr_data = 32'h0000_0028;
    tick();
    wr_valid = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd16;
    push(5'd16, 32'h28, 1'b1);
    tick();
    rd_req_valid = 1'b0;
    tick();
    tick();

    // Forwarding: write lands on the R1 transfer edge.
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd3;
    push(5'd3, 32'hDEAD_BEEF, 1'b1);
    tick();
    rd_req_valid = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();

    // Preload 0..3, then back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr = 5'(i);
      wr_data = 32'h10 + 32'(i);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_req_valid = 1'b1;
      rd_req_addr = 5'(i);
      push(5'(i), 32'h10 + 32'(i), 1'b1);
      check("b2b_req_ready", 32'(rd_req_ready), 32'd1);
      tick();
      check("b2b_pending_le2", 32'(pending <= 2'd2), 32'd1);
      if (i >= 1) begin
        check("b2b_rsp_valid", 32'(rd_rsp_valid), 32'd1);
        check("b2b_rsp_addr", 32'(rd_rsp_addr), 32'(i - 1));
      end
    end
    rd_req_valid = 1'b0;
    tick();
    check("b2b_last_addr", 32'(rd_rsp_addr), 32'd3);
    tick();
    check("b2b_drained", 32'(rd_rsp_valid), 32'd0);

    // Backpressure stall with a write to the stalled R1 address.
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd0;
    push(5'd0, 32'h10, 1'b1);
    tick();
    check("stall_ready_after1", 32'(rd_req_ready), 32'd1);
    rd_req_addr = 5'd1;
    push(5'd1, 32'hCAFE_0001, 1'b1);
    tick();
    rd_req_addr = 5'd2;
    for (int i = 0; i < 5; i++) begin
      check("stall_req_ready", 32'(rd_req_ready), 32'd0);
      check("stall_pending", 32'(pending), 32'd2);
      check("stall_rsp_addr", 32'(rd_rsp_addr), 32'd0);
      check("stall_rsp_data", rd_rsp_data, 32'h10);
      wr_valid = (i == 2);
      wr_addr = 5'd1;
      wr_data = 32'hCAFE_0001;
      tick();
    end
    wr_valid = 1'b0;
    rd_rsp_ready = 1'b1;
    push(5'd2, 32'h12, 1'b1);
    #1;
    check("release_req_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    repeat (3) tick();
    check("release_drained", 32'(pending), 32'd0);

    // Reset mid-operation with two requests in flight.
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd16;
    tick();
    rd_req_addr = 5'd5;
    tick();
    rd_req_valid = 1'b0;
    check("pre_reset_pending", 32'(pending), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("mid_reset_pending", 32'(pending), 32'd0);
    check("mid_reset_req_ready", 32'(rd_req_ready), 32'd1);
    check("mid_reset_rsp_data", rd_rsp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    rd_rsp_ready = 1'b1;
    tick();
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd16;
    push(5'd16, 32'h0, 1'b0);
    tick();
    rd_req_valid = 1'b0;
    repeat (3) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alu_result_reader
